csr_access_arbiter: RTL



---
 rtl/csr_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/csr_access_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/csr_arb_pkg.sv
// csr_arb_pkg: shared constants, FSM state and response-tag types for the CSR access arbiter
package csr_arb_pkg;
  localparam logic [31:0] CSR_GUARD_KEY  = 32'h0000_1234;
  localparam logic [31:0] CSR_GUARD_ADDR = 32'h0000_0004;
  localparam int          CSR_RD_LAT     = 1;
  localparam int          ID_W           = 2;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GUARD = 1'b1} state_t;
  typedef struct packed {
    logic            valid;
    logic            swallow;
    logic            is_rd;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
//   i_req  request vector      i_ptr   search start index
//   o_gnt  one-hot grant       o_found any request granted
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_found
);
  always_comb begin
    o_gnt   = '0;
    o_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!o_found && i_req[(int'(i_ptr) + i) % NUM_REQ]) begin
        o_gnt[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
        o_found = 1'b1;
      end
  end
endmodule

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: round-robin sharing of one CSR port with atomic guarded writes and response routing
//   i_req_*  per-requester request (held until o_req_ready)   o_rsp_*  per-requester response
//   o_csr_*  registered CSR drive   i_csr_dout_*  CSR read data/ack   o_err  sticky protocol error
module csr_access_arbiter
  import csr_arb_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter logic [31:0] GUARD_KEY  = CSR_GUARD_KEY,
  parameter logic [31:0] GUARD_ADDR = CSR_GUARD_ADDR
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ-1:0]    i_req_wr,
  input  logic [NUM_REQ-1:0]    i_req_guarded,
  input  logic [NUM_REQ*32-1:0] i_req_addr,
  input  logic [NUM_REQ*32-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [NUM_REQ*32-1:0] o_rsp_data,
  output logic [31:0]           o_csr_addr_32b,
  output logic                  o_csr_wren,
  output logic                  o_csr_rden,
  output logic [31:0]           o_csr_din_32b,
  input  logic [31:0]           i_csr_dout_32b,
  input  logic                  i_csr_dout_32b_valid,
  output logic                  o_err
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t              r_state;
  logic [IW-1:0]       r_rr, r_gid, w_gid, w_tid, w_rid, w_rr_nxt;
  logic [NUM_REQ-1:0]  w_req, w_gnt;
  logic                w_found, w_wr, w_gd;
  logic [31:0]         w_addr, w_wdata;
  tag_t                r_iss, r_tag;
  // Ready stays high for the whole issue cycle while the requester still shows the
  // accepted request, so mask it to avoid issuing the same access twice.
  assign w_req = i_req_valid & ~o_req_ready;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(IW)) u_rr (
    .i_req  (w_req),
    .i_ptr  (r_rr),
    .o_gnt  (w_gnt),
    .o_found(w_found)
  );
  always_comb begin
    w_gid = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_gnt[i]) w_gid = IW'(i);
  end
  assign w_tid    = (r_state == ST_GUARD) ? r_gid : w_gid;
  assign w_rr_nxt = (w_gid == IW'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
  assign w_rid    = IW'(r_tag.id);
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_wr    = 1'b0;
    w_gd    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (IW'(i) == w_tid) begin
        w_addr  = i_req_addr[i*32 +: 32];
        w_wdata = i_req_wdata[i*32 +: 32];
        w_wr    = i_req_wr[i];
        w_gd    = i_req_guarded[i];
      end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_rr           <= '0;
      r_gid          <= '0;
      r_iss          <= '0;
      r_tag          <= '0;
      o_req_ready    <= '0;
      o_rsp_valid    <= '0;
      o_rsp_data     <= '0;
      o_csr_addr_32b <= '0;
      o_csr_wren     <= 1'b0;
      o_csr_rden     <= 1'b0;
      o_csr_din_32b  <= '0;
      o_err          <= 1'b0;
    end else begin
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_csr_wren  <= 1'b0;
      o_csr_rden  <= 1'b0;
      r_iss       <= '0;
      r_tag       <= r_iss;
      if (r_state == ST_GUARD) begin
        // Target write must follow the key write with nothing in between.
        o_csr_wren            <= 1'b1;
        o_csr_addr_32b        <= w_addr;
        o_csr_din_32b         <= w_wdata;
        o_req_ready[w_tid]    <= 1'b1;
        r_iss                 <= '{valid: 1'b1, swallow: 1'b0, is_rd: 1'b0, id: ID_W'(r_gid)};
        r_state               <= ST_IDLE;
      end else if (w_found) begin
        r_rr <= w_rr_nxt;
        if (w_wr && w_gd) begin
          o_csr_wren     <= 1'b1;
          o_csr_addr_32b <= GUARD_ADDR;
          o_csr_din_32b  <= GUARD_KEY;
          r_gid          <= w_gid;
          r_iss          <= '{valid: 1'b1, swallow: 1'b1, is_rd: 1'b0, id: ID_W'(w_gid)};
          r_state        <= ST_GUARD;
        end else begin
          o_csr_wren         <= w_wr;
          o_csr_rden         <= ~w_wr;
          o_csr_addr_32b     <= w_addr;
          o_req_ready[w_gid] <= 1'b1;
          r_iss              <= '{valid: 1'b1, swallow: 1'b0, is_rd: ~w_wr, id: ID_W'(w_gid)};
          if (w_wr) o_csr_din_32b <= w_wdata;
        end
      end
      if (i_csr_dout_32b_valid != r_tag.valid) o_err <= 1'b1;
      if (i_csr_dout_32b_valid && r_tag.valid && !r_tag.swallow)
        for (int i = 0; i < NUM_REQ; i++)
          if (IW'(i) == w_rid) begin
            o_rsp_valid[i]          <= 1'b1;
            o_rsp_data[i*32 +: 32] <= r_tag.is_rd ? i_csr_dout_32b : 32'h0;
          end
    end
  end
endmodule
